// File: rtl/pipelined_riscv_uc.sv
// Control unit for the 5-stage RISC-V pipeline.
// Decodes in D, then carries the control word through D->E, E->M and M->W.
module pipelined_riscv_uc #(
    parameter bit SUPPORT_BNE = 1'b1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic [2:0] func3,
    input  logic [6:0] func7,
    input  logic       zeroE,
    input  logic       FlushE,
    output logic [1:0] ImmSrcD,
    output logic       ALUSrcE,
    output logic [2:0] ALUControlE,
    output logic       PCSrcE,
    output logic       MemWriteM,
    output logic       RegWriteM,
    output logic       RegWriteW,
    output logic [1:0] ResultSrcW,
    output logic       ResultSrcE0
);

    logic       reg_write_d;
    logic       alu_src_d;
    logic       mem_write_d;
    logic [1:0] result_src_d;
    logic       branch_d;
    logic [1:0] alu_op_d;
    logic       jump_d;
    logic [2:0] alu_control_d;

    logic       reg_write_e;
    logic [1:0] result_src_e;
    logic       mem_write_e;
    logic       jump_e;
    logic       branch_e;
    logic [2:0] func3_e;
    logic       cond_e;

    logic [1:0] result_src_m;

    // Only func7[5] distinguishes add/sub; the rest is not needed here.
    logic unused_func7;
    assign unused_func7 = ^{func7[6], func7[4:0]};

    // Main decoder: opcode to control fields; unknown opcodes decode as NOP.
    always_comb begin
        reg_write_d  = 1'b0;
        ImmSrcD      = 2'b00;
        alu_src_d    = 1'b0;
        mem_write_d  = 1'b0;
        result_src_d = 2'b00;
        branch_d     = 1'b0;
        alu_op_d     = 2'b00;
        jump_d       = 1'b0;
        case (opcode)
            7'b0000011: begin
                reg_write_d  = 1'b1;
                alu_src_d    = 1'b1;
                result_src_d = 2'b01;
            end
            7'b0100011: begin
                ImmSrcD     = 2'b01;
                alu_src_d   = 1'b1;
                mem_write_d = 1'b1;
            end
            7'b0110011: begin
                reg_write_d = 1'b1;
                alu_op_d    = 2'b10;
            end
            7'b0010011: begin
                reg_write_d = 1'b1;
                alu_src_d   = 1'b1;
                alu_op_d    = 2'b10;
            end
            7'b1100011: begin
                ImmSrcD  = 2'b10;
                branch_d = 1'b1;
                alu_op_d = 2'b01;
            end
            7'b1101111: begin
                reg_write_d  = 1'b1;
                ImmSrcD      = 2'b11;
                result_src_d = 2'b10;
                jump_d       = 1'b1;
            end
            default: ;
        endcase
    end

    // ALU decoder: ALUOp plus func3/func7 to the ALU operation code.
    always_comb begin
        alu_control_d = 3'b000;
        case (alu_op_d)
            2'b01: alu_control_d = 3'b001;
            2'b10: begin
                case (func3)
                    3'b000: alu_control_d = (opcode[5] & func7[5]) ?
                                            3'b001 : 3'b000;
                    3'b010: alu_control_d = 3'b101;
                    3'b110: alu_control_d = 3'b011;
                    3'b111: alu_control_d = 3'b010;
                    default: alu_control_d = 3'b000;
                endcase
            end
            default: alu_control_d = 3'b000;
        endcase
    end

    // D->E register: cleared on reset or flush, otherwise loads every cycle.
    always_ff @(posedge clock) begin
        if (reset || FlushE) begin
            reg_write_e  <= 1'b0;
            result_src_e <= 2'b00;
            mem_write_e  <= 1'b0;
            jump_e       <= 1'b0;
            branch_e     <= 1'b0;
            ALUControlE  <= 3'b000;
            ALUSrcE      <= 1'b0;
            func3_e      <= 3'b000;
        end else begin
            reg_write_e  <= reg_write_d;
            result_src_e <= result_src_d;
            mem_write_e  <= mem_write_d;
            jump_e       <= jump_d;
            branch_e     <= branch_d;
            ALUControlE  <= alu_control_d;
            ALUSrcE      <= alu_src_d;
            func3_e      <= func3;
        end
    end

    // Branch condition selected by the branch's func3 in Execute.
    always_comb begin
        cond_e = 1'b0;
        case (func3_e)
            3'b000: cond_e = zeroE;
            3'b001: cond_e = SUPPORT_BNE ? ~zeroE : 1'b0;
            default: cond_e = 1'b0;
        endcase
    end

    assign PCSrcE      = jump_e | (branch_e & cond_e);
    assign ResultSrcE0 = result_src_e[0];

    // E->M and M->W registers: load every cycle, cleared only by reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            RegWriteM    <= 1'b0;
            result_src_m <= 2'b00;
            MemWriteM    <= 1'b0;
            RegWriteW    <= 1'b0;
            ResultSrcW   <= 2'b00;
        end else begin
            RegWriteM    <= reg_write_e;
            result_src_m <= result_src_e;
            MemWriteM    <= mem_write_e;
            RegWriteW    <= RegWriteM;
            ResultSrcW   <= result_src_m;
        end
    end

endmodule

// File: tb/tb_pipelined_riscv_uc.sv
// Directed bench for pipelined_riscv_uc.
// Two instances: default (bne supported) and SUPPORT_BNE=0.
module tb_pipelined_riscv_uc;

    logic       clock = 1'b0;
    logic       reset;
    logic [6:0] opcode;
    logic [2:0] func3;
    logic [6:0] func7;
    logic       zeroE;
    logic       FlushE;

    logic [1:0] ImmSrcD, ResultSrcW;
    logic       ALUSrcE, PCSrcE, MemWriteM, RegWriteM, RegWriteW, ResultSrcE0;
    logic [2:0] ALUControlE;

    logic [1:0] imm0, rsw0;
    logic       als0, pcs0, mw0, rwm0, rww0, rse0;
    logic [2:0] alc0;

    int total = 0;
    int bad = 0;

    always #5 clock = ~clock;

    pipelined_riscv_uc dut (
        .clock(clock), .reset(reset), .opcode(opcode), .func3(func3),
        .func7(func7), .zeroE(zeroE), .FlushE(FlushE),
        .ImmSrcD(ImmSrcD), .ALUSrcE(ALUSrcE), .ALUControlE(ALUControlE),
        .PCSrcE(PCSrcE), .MemWriteM(MemWriteM), .RegWriteM(RegWriteM),
        .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW),
        .ResultSrcE0(ResultSrcE0)
    );

    pipelined_riscv_uc #(.SUPPORT_BNE(1'b0)) dut0 (
        .clock(clock), .reset(reset), .opcode(opcode), .func3(func3),
        .func7(func7), .zeroE(zeroE), .FlushE(FlushE),
        .ImmSrcD(imm0), .ALUSrcE(als0), .ALUControlE(alc0),
        .PCSrcE(pcs0), .MemWriteM(mw0), .RegWriteM(rwm0),
        .RegWriteW(rww0), .ResultSrcW(rsw0), .ResultSrcE0(rse0)
    );

    task automatic chk(input string tag, input logic [2:0] obs,
                       input logic [2:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic instr(input logic [6:0] op, input logic [2:0] f3,
                         input logic [6:0] f7);
        opcode = op;
        func3  = f3;
        func7  = f7;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; FlushE = 1'b0; zeroE = 1'b0;
        instr(7'h00, 3'b000, 7'h00);
        step();
        chk("rst_alusrc", {2'b0, ALUSrcE}, 3'd0);
        chk("rst_aluctl", ALUControlE, 3'd0);
        chk("rst_pcsrc", {2'b0, PCSrcE}, 3'd0);
        chk("rst_memw", {2'b0, MemWriteM}, 3'd0);
        chk("rst_rwm", {2'b0, RegWriteM}, 3'd0);
        chk("rst_rww", {2'b0, RegWriteW}, 3'd0);
        chk("rst_rsw", {1'b0, ResultSrcW}, 3'd0);
        chk("rst_rse0", {2'b0, ResultSrcE0}, 3'd0);
        reset = 1'b0;
        step();

        // ALU instructions back to back
        instr(7'b0110011, 3'b000, 7'b0000000);
        step();
        chk("add_aluctl", ALUControlE, 3'b000);
        chk("add_alusrc", {2'b0, ALUSrcE}, 3'd0);
        instr(7'b0110011, 3'b000, 7'b0100000);
        step();
        chk("sub_aluctl", ALUControlE, 3'b001);
        chk("add_rwm", {2'b0, RegWriteM}, 3'd1);
        chk("add_memw", {2'b0, MemWriteM}, 3'd0);
        instr(7'b0110011, 3'b110, 7'b0000000);
        step();
        chk("or_aluctl", ALUControlE, 3'b011);
        chk("add_rww", {2'b0, RegWriteW}, 3'd1);
        chk("add_rsw", {1'b0, ResultSrcW}, 3'b000);
        instr(7'b0010011, 3'b010, 7'b0100000);
        step();
        chk("slti_aluctl", ALUControlE, 3'b101);
        chk("slti_alusrc", {2'b0, ALUSrcE}, 3'd1);

        // load then store
        instr(7'b0000011, 3'b010, 7'b0000000);
        chk("lw_imm", {1'b0, ImmSrcD}, 3'b000);
        step();
        chk("lw_rse0", {2'b0, ResultSrcE0}, 3'd1);
        chk("lw_aluctl", ALUControlE, 3'b000);
        chk("lw_alusrc", {2'b0, ALUSrcE}, 3'd1);
        instr(7'b0100011, 3'b010, 7'b0000000);
        chk("sw_imm", {1'b0, ImmSrcD}, 3'b001);
        step();
        chk("sw_rse0", {2'b0, ResultSrcE0}, 3'd0);
        chk("lw_rwm", {2'b0, RegWriteM}, 3'd1);
        instr(7'h00, 3'b000, 7'h00);
        step();
        chk("sw_memw", {2'b0, MemWriteM}, 3'd1);
        chk("sw_rwm", {2'b0, RegWriteM}, 3'd0);
        chk("lw_rww", {2'b0, RegWriteW}, 3'd1);
        chk("lw_rsw", {1'b0, ResultSrcW}, 3'b001);
        step();
        chk("sw_rww", {2'b0, RegWriteW}, 3'd0);
        chk("nop_memw", {2'b0, MemWriteM}, 3'd0);

        // branches and jal
        instr(7'b1100011, 3'b000, 7'h00);
        chk("beq_imm", {1'b0, ImmSrcD}, 3'b010);
        step();
        zeroE = 1'b1; #1;
        chk("beq_z1", {2'b0, PCSrcE}, 3'd1);
        chk("beq_z1_nobne", {2'b0, pcs0}, 3'd1);
        chk("beq_aluctl", ALUControlE, 3'b001);
        zeroE = 1'b0; #1;
        chk("beq_z0", {2'b0, PCSrcE}, 3'd0);
        instr(7'b1100011, 3'b001, 7'h00);
        step();
        chk("beq_rwm", {2'b0, RegWriteM}, 3'd0);
        chk("bne_z0", {2'b0, PCSrcE}, 3'd1);
        chk("bne_z0_nobne", {2'b0, pcs0}, 3'd0);
        zeroE = 1'b1; #1;
        chk("bne_z1", {2'b0, PCSrcE}, 3'd0);
        chk("bne_z1_nobne", {2'b0, pcs0}, 3'd0);
        instr(7'b1101111, 3'b000, 7'h00);
        chk("jal_imm", {1'b0, ImmSrcD}, 3'b011);
        step();
        chk("jal_z1", {2'b0, PCSrcE}, 3'd1);
        chk("beq_rww", {2'b0, RegWriteW}, 3'd0);
        zeroE = 1'b0; #1;
        chk("jal_z0", {2'b0, PCSrcE}, 3'd1);
        instr(7'h00, 3'b000, 7'h00);
        zeroE = 1'b1;
        step();
        chk("nop_pcsrc", {2'b0, PCSrcE}, 3'd0);
        chk("bne_rww", {2'b0, RegWriteW}, 3'd0);
        step();
        chk("jal_rww", {2'b0, RegWriteW}, 3'd1);
        chk("jal_rsw", {1'b0, ResultSrcW}, 3'b010);

        // flush a load in D
        zeroE = 1'b0;
        instr(7'b0000011, 3'b010, 7'h00);
        FlushE = 1'b1;
        step();
        FlushE = 1'b0;
        instr(7'h00, 3'b000, 7'h00);
        chk("flush_rse0", {2'b0, ResultSrcE0}, 3'd0);
        chk("flush_alusrc", {2'b0, ALUSrcE}, 3'd0);
        step();
        chk("flush_rwm", {2'b0, RegWriteM}, 3'd0);
        step();
        chk("flush_rww", {2'b0, RegWriteW}, 3'd0);

        // flush coinciding with a taken jump
        instr(7'b1101111, 3'b000, 7'h00);
        step();
        instr(7'h00, 3'b000, 7'h00);
        FlushE = 1'b1; #1;
        chk("flushjal_pcsrc", {2'b0, PCSrcE}, 3'd1);
        step();
        FlushE = 1'b0; #1;
        chk("flushjal_after", {2'b0, PCSrcE}, 3'd0);

        // reset with lw in M and sw in E
        instr(7'b0000011, 3'b010, 7'h00);
        step();
        instr(7'b0100011, 3'b010, 7'h00);
        step();
        instr(7'h00, 3'b000, 7'h00);
        reset = 1'b1;
        step();
        chk("rsmid_memw", {2'b0, MemWriteM}, 3'd0);
        chk("rsmid_rwm", {2'b0, RegWriteM}, 3'd0);
        chk("rsmid_rww", {2'b0, RegWriteW}, 3'd0);
        chk("rsmid_rse0", {2'b0, ResultSrcE0}, 3'd0);
        reset = 1'b0;
        step();
        chk("rsmid_memw2", {2'b0, MemWriteM}, 3'd0);
        chk("rsmid_rww2", {2'b0, RegWriteW}, 3'd0);
        step();
        chk("rsmid_rww3", {2'b0, RegWriteW}, 3'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
